// File: rtl/brightness_pe_array.sv
// ============================================================================
// brightness_pe_array
// ----------------------------------------------------------------------------
// Brightness-adjust processing element. It accepts one operand set of four
// 8-bit unsigned pixels and four 16-bit signed offsets. It computes one lane
// per cycle as clamp(pixel + offset, 0, 255) and publishes all four results
// together on result_arr. It then writes the results to an output RAM, one
// word per cycle, starting at BASE_ADDR.
//
// The latency is fixed, counted from the edge that accepts tpu_valid (E0):
//   result_valid is high after E4.
//   wr_en is high after E5..E8.
//   done is high after E9, and the block is idle again at that point.
//
// All outputs are registered. Each one describes the cycle the FSM has just
// completed.
//
// Ports
//   clk          : single clock; all state changes on its rising edge
//   reset        : synchronous, active-low reset
//   tpu_valid    : one-cycle request; data_arr / wt_arr hold new operands
//   data_arr     : 4 x 8-bit unsigned pixels, lane i = [8i+7:8i]
//   wt_arr       : 4 x 16-bit signed offsets, lane i = [16i+15:16i]
//   result_arr   : 4 x 8-bit results, held until the next result_valid
//   result_valid : one-cycle pulse marking result_arr as fresh
//   wr_en        : output-RAM write strobe
//   wr_addr      : output-RAM word address (0 while wr_en is low)
//   wr_data      : output-RAM write data (0 while wr_en is low)
//   busy         : high while an operation is in flight
//   done         : one-cycle pulse at the end of the write-back
//   drop_err     : sticky flag, set by tpu_valid arriving while busy
// ============================================================================
module brightness_pe_array #(
    parameter logic [5:0] BASE_ADDR = 6'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tpu_valid,
    input  logic [31:0] data_arr,
    input  logic [63:0] wt_arr,
    output logic [31:0] result_arr,
    output logic        result_valid,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        drop_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] data_q;
    logic [63:0] wt_q;
    logic [7:0]  lane_res [4];

    logic [7:0]  cur_pix;
    logic [15:0] cur_off;
    logic [7:0]  cur_res;

    // Adds in 18 bits so that the largest sum (255 + 32767) and the smallest
    // sum (0 - 32768) cannot overflow before the clamp is applied.
    function automatic logic [7:0] clamp_add(input logic [7:0] pix, input logic [15:0] off);
        logic signed [17:0] sum;
        sum = $signed({10'd0, pix}) + $signed({{2{off[15]}}, off});
        if (sum < 18'sd0)
            return 8'd0;
        else if (sum > 18'sd255)
            return 8'd255;
        else
            return sum[7:0];
    endfunction

    // The lane counter selects which captured operand pair feeds the single
    // shared adder/clamp datapath.
    always_comb begin
        cur_pix = data_q[{cnt, 3'b000} +: 8];
        cur_off = wt_q[{cnt, 4'b0000} +: 16];
        cur_res = clamp_add(cur_pix, cur_off);
    end

    // Main FSM. The pulse outputs default to 0 every cycle, and each state
    // re-asserts its own pulse. A request that arrives in any non-IDLE state
    // is dropped and recorded in drop_err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            data_q       <= 32'd0;
            wt_q         <= 64'd0;
            lane_res[0]  <= 8'd0;
            lane_res[1]  <= 8'd0;
            lane_res[2]  <= 8'd0;
            lane_res[3]  <= 8'd0;
            result_arr   <= 32'd0;
            result_valid <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= 6'd0;
            wr_data      <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= 6'd0;
            wr_data      <= 8'd0;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (tpu_valid) begin
                        data_q <= data_arr;
                        wt_q   <= wt_arr;
                        cnt    <= 2'd0;
                        busy   <= 1'b1;
                        state  <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    if (tpu_valid)
                        drop_err <= 1'b1;
                    lane_res[cnt] <= cur_res;
                    cnt           <= cnt + 2'd1;
                    // Lane 3 is still being registered on this edge, so
                    // result_arr takes it directly from the datapath.
                    if (cnt == 2'd3) begin
                        result_arr   <= {cur_res, lane_res[2], lane_res[1], lane_res[0]};
                        result_valid <= 1'b1;
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    if (tpu_valid)
                        drop_err <= 1'b1;
                    wr_en   <= 1'b1;
                    // The 6-bit add wraps modulo 64 by construction.
                    wr_addr <= BASE_ADDR + {4'd0, cnt};
                    wr_data <= lane_res[cnt];
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= DONE;
                end

                DONE: begin
                    if (tpu_valid)
                        drop_err <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brightness_pe_array.sv
// ============================================================================
// tb_brightness_pe_array
// ----------------------------------------------------------------------------
// Directed testbench for brightness_pe_array. It uses two instances that share
// the same inputs: dut_a uses the default BASE_ADDR (16), and dut_b uses
// BASE_ADDR = 62, so its write addresses wrap past 63. Inputs are driven and
// outputs sampled 1 ns after each rising clock edge.
// ============================================================================
module tb_brightness_pe_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        tpu_valid;
    logic [31:0] data_arr;
    logic [63:0] wt_arr;

    logic [31:0] result_arr_a,   result_arr_b;
    logic        result_valid_a, result_valid_b;
    logic        wr_en_a,        wr_en_b;
    logic [5:0]  wr_addr_a,      wr_addr_b;
    logic [7:0]  wr_data_a,      wr_data_b;
    logic        busy_a,         busy_b;
    logic        done_a,         done_b;
    logic        drop_err_a,     drop_err_b;

    int assert_count = 0;
    int fail_count   = 0;

    localparam logic [31:0] BASIC_DATA = 32'h40302010;
    localparam logic [63:0] BASIC_WT   = 64'h0001_0002_FFF0_0005;
    localparam logic [31:0] BASIC_RES  = 32'h41321015;
    localparam logic [31:0] SAT_DATA   = 32'h008005FA;
    localparam logic [63:0] SAT_WT     = 64'h8000_7FFF_FFEC_000A;
    localparam logic [31:0] SAT_RES    = 32'h00FF00FF;
    localparam logic [31:0] EDGE_DATA  = 32'hFF000180;
    localparam logic [63:0] EDGE_WT    = 64'h0000_7FFF_FFFF_8000;
    localparam logic [31:0] EDGE_RES   = 32'hFFFF0000;

    always #5 clk = ~clk;

    brightness_pe_array dut_a (
        .clk          (clk),
        .reset        (reset),
        .tpu_valid    (tpu_valid),
        .data_arr     (data_arr),
        .wt_arr       (wt_arr),
        .result_arr   (result_arr_a),
        .result_valid (result_valid_a),
        .wr_en        (wr_en_a),
        .wr_addr      (wr_addr_a),
        .wr_data      (wr_data_a),
        .busy         (busy_a),
        .done         (done_a),
        .drop_err     (drop_err_a)
    );

    brightness_pe_array #(.BASE_ADDR(6'd62)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .tpu_valid    (tpu_valid),
        .data_arr     (data_arr),
        .wt_arr       (wt_arr),
        .result_arr   (result_arr_b),
        .result_valid (result_valid_b),
        .wr_en        (wr_en_b),
        .wr_addr      (wr_addr_b),
        .wr_data      (wr_data_b),
        .busy         (busy_b),
        .done         (done_b),
        .drop_err     (drop_err_b)
    );

    // Counts every comparison and reports each mismatch on a single line.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand set with a one-cycle tpu_valid pulse.
    task automatic applyStimulus(input logic [31:0] d, input logic [63:0] w);
        data_arr  = d;
        wt_arr    = w;
        tpu_valid = 1'b1;
        tick();
        tpu_valid = 1'b0;
    endtask

    // Every output of both instances must read zero.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, " result_arr_a"}, 64'(result_arr_a), 64'd0);
        checkOutput({tag, " result_valid_a"}, 64'(result_valid_a), 64'd0);
        checkOutput({tag, " wr_en_a"}, 64'(wr_en_a), 64'd0);
        checkOutput({tag, " wr_addr_a"}, 64'(wr_addr_a), 64'd0);
        checkOutput({tag, " wr_data_a"}, 64'(wr_data_a), 64'd0);
        checkOutput({tag, " busy_a"}, 64'(busy_a), 64'd0);
        checkOutput({tag, " done_a"}, 64'(done_a), 64'd0);
        checkOutput({tag, " drop_err_a"}, 64'(drop_err_a), 64'd0);
        checkOutput({tag, " result_arr_b"}, 64'(result_arr_b), 64'd0);
        checkOutput({tag, " busy_b"}, 64'(busy_b), 64'd0);
        checkOutput({tag, " drop_err_b"}, 64'(drop_err_b), 64'd0);
    endtask

    // Walks edges E1..E9 after an accepted request and checks the expected
    // timeline on both instances. intrude_a and intrude_b give the edges at
    // which an extra tpu_valid is sampled (-1 for none).
    task automatic runOp(input string name, input logic [31:0] exp_res,
                         input int intrude_a, input int intrude_b);
        logic [7:0] exp_lane;
        logic [5:0] exp_addr_a;
        logic [5:0] exp_addr_b;
        bit         in_write;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (cyc == intrude_a || cyc == intrude_b) begin
                data_arr  = 32'hFFFFFFFF;
                wt_arr    = 64'h7FFF_7FFF_7FFF_7FFF;
                tpu_valid = 1'b1;
            end
            tick();
            tpu_valid = 1'b0;

            in_write   = (cyc >= 5 && cyc <= 8);
            exp_lane   = in_write ? 8'(exp_res >> (8 * (cyc - 5))) : 8'd0;
            exp_addr_a = in_write ? 6'(16 + cyc - 5) : 6'd0;
            exp_addr_b = in_write ? 6'(62 + cyc - 5) : 6'd0;

            checkOutput($sformatf("%s E%0d result_valid_a", name, cyc), 64'(result_valid_a), 64'(cyc == 4));
            checkOutput($sformatf("%s E%0d result_valid_b", name, cyc), 64'(result_valid_b), 64'(cyc == 4));
            if (cyc >= 4) begin
                checkOutput($sformatf("%s E%0d result_arr_a", name, cyc), 64'(result_arr_a), 64'(exp_res));
                checkOutput($sformatf("%s E%0d result_arr_b", name, cyc), 64'(result_arr_b), 64'(exp_res));
            end
            checkOutput($sformatf("%s E%0d wr_en_a", name, cyc), 64'(wr_en_a), 64'(in_write));
            checkOutput($sformatf("%s E%0d wr_en_b", name, cyc), 64'(wr_en_b), 64'(in_write));
            checkOutput($sformatf("%s E%0d wr_addr_a", name, cyc), 64'(wr_addr_a), 64'(exp_addr_a));
            checkOutput($sformatf("%s E%0d wr_addr_b", name, cyc), 64'(wr_addr_b), 64'(exp_addr_b));
            checkOutput($sformatf("%s E%0d wr_data_a", name, cyc), 64'(wr_data_a), 64'(exp_lane));
            checkOutput($sformatf("%s E%0d wr_data_b", name, cyc), 64'(wr_data_b), 64'(exp_lane));
            checkOutput($sformatf("%s E%0d done_a", name, cyc), 64'(done_a), 64'(cyc == 9));
            checkOutput($sformatf("%s E%0d done_b", name, cyc), 64'(done_b), 64'(cyc == 9));
            checkOutput($sformatf("%s E%0d busy_a", name, cyc), 64'(busy_a), 64'(cyc <= 8));
        end
    endtask

    initial begin
        reset     = 1'b0;
        tpu_valid = 1'b1;
        data_arr  = BASIC_DATA;
        wt_arr    = BASIC_WT;

        // Reset held low while a request is presented: the request must be ignored.
        tick();
        tick();
        checkAllZero("reset");
        tpu_valid = 1'b0;
        reset     = 1'b1;
        tick();
        checkOutput("post-reset busy_a", 64'(busy_a), 64'd0);

        // Operands held with tpu_valid low must not start an operation.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("idle%0d busy_a", i), 64'(busy_a), 64'd0);
            checkOutput($sformatf("idle%0d wr_en_a", i), 64'(wr_en_a), 64'd0);
            checkOutput($sformatf("idle%0d result_valid_a", i), 64'(result_valid_a), 64'd0);
        end

        // Basic operation with the reference vector.
        applyStimulus(BASIC_DATA, BASIC_WT);
        checkOutput("basic E0 busy_a", 64'(busy_a), 64'd1);
        runOp("basic", BASIC_RES, -1, -1);
        checkOutput("basic drop_err_a", 64'(drop_err_a), 64'd0);

        // Saturation at both ends, including the 0x7FFF and 0x8000 offsets.
        applyStimulus(SAT_DATA, SAT_WT);
        runOp("sat", SAT_RES, -1, -1);

        // Collision: extra requests at E2 and in DONE (E9) are dropped.
        applyStimulus(BASIC_DATA, BASIC_WT);
        runOp("collide", BASIC_RES, 2, 9);
        checkOutput("collide drop_err_a", 64'(drop_err_a), 64'd1);
        checkOutput("collide drop_err_b", 64'(drop_err_b), 64'd1);

        // A request one cycle after done is accepted.
        applyStimulus(EDGE_DATA, EDGE_WT);
        runOp("edge", EDGE_RES, -1, -1);
        checkOutput("edge drop_err_a sticky", 64'(drop_err_a), 64'd1);

        // Reset abort after the second write of an operation.
        applyStimulus(BASIC_DATA, BASIC_WT);
        for (int i = 0; i < 6; i++)
            tick();
        checkOutput("abort pre wr_addr_a", 64'(wr_addr_a), 64'd17);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkAllZero("abort");
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("abort+%0d wr_en_a", i), 64'(wr_en_a), 64'd0);
            checkOutput($sformatf("abort+%0d done_a", i), 64'(done_a), 64'd0);
            checkOutput($sformatf("abort+%0d result_valid_a", i), 64'(result_valid_a), 64'd0);
            checkOutput($sformatf("abort+%0d busy_a", i), 64'(busy_a), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
